// File: rtl/chunk_row_burster_if.sv
// Row-descriptor and burst-command streams of chunk_row_burster.
// master: row producer / cmd consumer; slave: the burster.
interface chunk_row_burster_if #(
   parameter int GBW    = 32,
   parameter int VSIZE  = 16,
   parameter int LEN_BW = 16,
   parameter int BMAX   = 8
);
   localparam int V_BW = $clog2(VSIZE);
   localparam int BBW  = $clog2(BMAX);

   logic              row_rdy;
   logic              row_ack;
   logic [GBW-1:0]    i_row_linear;
   logic              i_row_islast;
   logic [V_BW-1:0]   i_row_pad;
   logic [LEN_BW-1:0] i_row_len;

   logic              cmd_rdy;
   logic              cmd_ack;
   logic [GBW-1:0]    o_cmd_addr;
   logic [BBW-1:0]    o_cmd_len;
   logic [V_BW-1:0]   o_cmd_pad;
   logic              o_cmd_rowlast;
   logic              o_cmd_islast;

   modport master (
      output row_rdy, i_row_linear, i_row_islast,
      output i_row_pad, i_row_len, cmd_ack,
      input  row_ack, cmd_rdy, o_cmd_addr, o_cmd_len,
      input  o_cmd_pad, o_cmd_rowlast, o_cmd_islast
   );

   modport slave (
      input  row_rdy, i_row_linear, i_row_islast,
      input  i_row_pad, i_row_len, cmd_ack,
      output row_ack, cmd_rdy, o_cmd_addr, o_cmd_len,
      output o_cmd_pad, o_cmd_rowlast, o_cmd_islast
   );
endinterface

// File: rtl/chunk_row_burster.sv
// Splits row descriptors into bursts that never cross a BMAX-vector boundary.
// Ports: i_clk, i_rst (async active-low), bus (row in / cmd out, slave side).
module chunk_row_burster #(
   parameter int GBW    = 32,
   parameter int VSIZE  = 16,
   parameter int LEN_BW = 16,
   parameter int BMAX   = 8
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   chunk_row_burster_if.slave   bus
);
   localparam int V_BW = $clog2(VSIZE);
   localparam int BBW  = $clog2(BMAX);
   localparam int CW   = LEN_BW + 1;

   typedef enum logic {S_IDLE, S_BUSY} state_t;

   state_t            state_q, state_d;
   logic [GBW-1:0]    addr_q;
   logic [LEN_BW-1:0] remain_q;
   logic              islast_q;
   logic [V_BW-1:0]   pad_q;

   logic [CW-1:0]     room, need, blen;
   logic              rowlast;
   logic              take, step;

   // room to the next aligned boundary is 1..BMAX
   always_comb begin
      room    = CW'(BMAX) - CW'(addr_q[BBW-1:0]);
      need    = CW'(remain_q) + CW'(1);
      rowlast = (need <= room);
      blen    = rowlast ? need : room;
   end

   always_comb begin
      state_d = state_q;
      take    = 1'b0;
      step    = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (bus.row_rdy) begin
               take    = 1'b1;
               state_d = S_BUSY;
            end
         end
         S_BUSY: begin
            if (bus.cmd_ack) begin
               if (!rowlast) begin
                  step = 1'b1;
               end else if (bus.row_rdy) begin
                  // next row loads on the final ack: no bubble
                  take = 1'b1;
               end else begin
                  state_d = S_IDLE;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         addr_q   <= '0;
         remain_q <= '0;
         islast_q <= 1'b0;
         pad_q    <= '0;
      end else if (take) begin
         addr_q   <= bus.i_row_linear;
         remain_q <= bus.i_row_len;
         islast_q <= bus.i_row_islast;
         pad_q    <= bus.i_row_pad;
      end else if (step) begin
         addr_q   <= addr_q + GBW'(blen);
         remain_q <= remain_q - LEN_BW'(blen);
         pad_q    <= '0;
      end
   end

   // gate with reset so a held row_rdy is not acked during reset
   assign bus.row_ack       = take & i_rst;
   assign bus.cmd_rdy       = (state_q == S_BUSY);
   assign bus.o_cmd_addr    = addr_q;
   assign bus.o_cmd_len     = BBW'(blen - CW'(1));
   assign bus.o_cmd_pad     = pad_q;
   assign bus.o_cmd_rowlast = rowlast;
   assign bus.o_cmd_islast  = rowlast & islast_q;
endmodule

// File: tb/tb_chunk_row_burster.sv
// Directed bench for chunk_row_burster.
// Drives rows / acks at negedge+posedge, checks outputs at negedge.
module tb_chunk_row_burster;
   logic clk;
   logic rst_n;
   int   n_cmp = 0;
   int   n_bad = 0;

   chunk_row_burster_if #(
      .GBW(32), .VSIZE(16), .LEN_BW(16), .BMAX(8)
   ) bus ();

   chunk_row_burster #(
      .GBW(32), .VSIZE(16), .LEN_BW(16), .BMAX(8)
   ) dut (
      .i_clk (clk),
      .i_rst (rst_n),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag,
                      input logic [63:0] obs,
                      input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%0h expected=%0h",
                tag, obs, exp);
      end
   endtask

   // called at a negedge, returns at a negedge after the accept edge
   task automatic send_row(input string tag,
                           input logic [31:0] lin,
                           input logic [15:0] len,
                           input logic [3:0]  pad,
                           input logic        il);
      int w;
      bus.i_row_linear = lin;
      bus.i_row_len    = len;
      bus.i_row_pad    = pad;
      bus.i_row_islast = il;
      bus.row_rdy      = 1'b1;
      #1;
      w = 0;
      while (!bus.row_ack && w < 20) begin
         @(negedge clk);
         w++;
      end
      chk({tag, ".row_ack"}, 64'(bus.row_ack), 64'd1);
      @(posedge clk);
      #1 bus.row_rdy = 1'b0;
      @(negedge clk);
   endtask

   task automatic expect_cmd(input string tag,
                             input logic [31:0] a,
                             input logic [2:0]  l,
                             input logic [3:0]  p,
                             input logic        rl,
                             input logic        il);
      int w;
      w = 0;
      while (!bus.cmd_rdy && w < 20) begin
         @(negedge clk);
         w++;
      end
      chk({tag, ".rdy"}, 64'(bus.cmd_rdy), 64'd1);
      if (bus.cmd_rdy) begin
         chk({tag, ".addr"}, 64'(bus.o_cmd_addr), 64'(a));
         chk({tag, ".len"}, 64'(bus.o_cmd_len), 64'(l));
         chk({tag, ".pad"}, 64'(bus.o_cmd_pad), 64'(p));
         chk({tag, ".rowlast"},
             64'(bus.o_cmd_rowlast), 64'(rl));
         chk({tag, ".islast"},
             64'(bus.o_cmd_islast), 64'(il));
         bus.cmd_ack = 1'b1;
         @(posedge clk);
         #1 bus.cmd_ack = 1'b0;
         @(negedge clk);
      end
   endtask

   initial begin
      logic [31:0] s_addr;
      logic [2:0]  s_len;
      logic [3:0]  s_pad;
      logic        s_rl;
      logic        held;
      logic        done;
      logic        ack;
      int          sum;
      int          nb;

      rst_n            = 1'b0;
      bus.row_rdy      = 1'b1;
      bus.cmd_ack      = 1'b0;
      bus.i_row_linear = '0;
      bus.i_row_len    = '0;
      bus.i_row_pad    = '0;
      bus.i_row_islast = 1'b0;

      // reset: nothing acked or issued even with row_rdy high
      repeat (3) @(negedge clk);
      chk("rst.cmd_rdy", 64'(bus.cmd_rdy), 64'd0);
      chk("rst.row_ack", 64'(bus.row_ack), 64'd0);
      bus.row_rdy = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         chk("idle.cmd_rdy", 64'(bus.cmd_rdy), 64'd0);
      end

      // split: 21 vectors from 5 -> 3+8+8+2
      send_row("split", 32'd5, 16'd20, 4'd3, 1'b1);
      chk("split.lat", 64'(bus.cmd_rdy), 64'd1);
      expect_cmd("split0", 32'd5, 3'd2, 4'd3, 1'b0, 1'b0);
      expect_cmd("split1", 32'd8, 3'd7, 4'd0, 1'b0, 1'b0);
      expect_cmd("split2", 32'd16, 3'd7, 4'd0, 1'b0, 1'b0);
      expect_cmd("split3", 32'd24, 3'd1, 4'd0, 1'b1, 1'b1);
      repeat (3) begin
         chk("split.after", 64'(bus.cmd_rdy), 64'd0);
         @(negedge clk);
      end

      // aligned full burst and single vector
      send_row("algn", 32'd16, 16'd7, 4'd0, 1'b0);
      expect_cmd("algn0", 32'd16, 3'd7, 4'd0, 1'b1, 1'b0);
      chk("algn.after", 64'(bus.cmd_rdy), 64'd0);
      send_row("one", 32'd7, 16'd0, 4'd5, 1'b1);
      expect_cmd("one0", 32'd7, 3'd0, 4'd5, 1'b1, 1'b1);
      chk("one.after", 64'(bus.cmd_rdy), 64'd0);

      // back-to-back rows with row_rdy and cmd_ack held
      bus.i_row_linear = 32'd0;
      bus.i_row_len    = 16'd3;
      bus.i_row_pad    = 4'd0;
      bus.i_row_islast = 1'b0;
      bus.row_rdy      = 1'b1;
      bus.cmd_ack      = 1'b1;
      #1;
      chk("b2b.ack0", 64'(bus.row_ack), 64'd1);
      @(posedge clk);
      #1;
      bus.i_row_linear = 32'd32;
      bus.i_row_islast = 1'b1;
      @(negedge clk);
      chk("b2b.rdy0", 64'(bus.cmd_rdy), 64'd1);
      chk("b2b.addr0", 64'(bus.o_cmd_addr), 64'd0);
      chk("b2b.len0", 64'(bus.o_cmd_len), 64'd3);
      chk("b2b.isl0", 64'(bus.o_cmd_islast), 64'd0);
      chk("b2b.ack1", 64'(bus.row_ack), 64'd1);
      @(posedge clk);
      #1 bus.row_rdy = 1'b0;
      @(negedge clk);
      chk("b2b.rdy1", 64'(bus.cmd_rdy), 64'd1);
      chk("b2b.addr1", 64'(bus.o_cmd_addr), 64'd32);
      chk("b2b.len1", 64'(bus.o_cmd_len), 64'd3);
      chk("b2b.isl1", 64'(bus.o_cmd_islast), 64'd1);
      chk("b2b.noack", 64'(bus.row_ack), 64'd0);
      @(posedge clk);
      #1 bus.cmd_ack = 1'b0;
      @(negedge clk);
      chk("b2b.idle", 64'(bus.cmd_rdy), 64'd0);

      // backpressure: 18 vectors from 3 -> 5+8+5
      send_row("bp", 32'd3, 16'd17, 4'd2, 1'b0);
      held = 1'b0;
      done = 1'b0;
      sum  = 0;
      nb   = 0;
      s_addr = '0;
      s_len  = '0;
      s_pad  = '0;
      s_rl   = 1'b0;
      for (int c = 0; c < 400 && !done; c++) begin
         if (bus.cmd_rdy) begin
            if (held) begin
               chk("bp.hold.addr",
                   64'(bus.o_cmd_addr), 64'(s_addr));
               chk("bp.hold.len",
                   64'(bus.o_cmd_len), 64'(s_len));
               chk("bp.hold.pad",
                   64'(bus.o_cmd_pad), 64'(s_pad));
               chk("bp.hold.rl",
                   64'(bus.o_cmd_rowlast), 64'(s_rl));
            end
            chk("bp.addr", 64'(bus.o_cmd_addr),
                64'(32'd3 + 32'(sum)));
            ack = ($urandom_range(0, 99) < 30);
            bus.cmd_ack = ack;
            if (ack) begin
               sum += int'(bus.o_cmd_len) + 1;
               nb++;
               done = bus.o_cmd_rowlast;
               held = 1'b0;
            end else begin
               held   = 1'b1;
               s_addr = bus.o_cmd_addr;
               s_len  = bus.o_cmd_len;
               s_pad  = bus.o_cmd_pad;
               s_rl   = bus.o_cmd_rowlast;
            end
         end
         @(posedge clk);
         #1 bus.cmd_ack = 1'b0;
         @(negedge clk);
      end
      chk("bp.done", 64'(done), 64'd1);
      chk("bp.sum", 64'(sum), 64'd18);
      chk("bp.bursts", 64'(nb), 64'd3);
      chk("bp.after", 64'(bus.cmd_rdy), 64'd0);

      // mid-row reset after 2 of 4 bursts
      send_row("mid", 32'd0, 16'd31, 4'd1, 1'b1);
      expect_cmd("mid0", 32'd0, 3'd7, 4'd1, 1'b0, 1'b0);
      expect_cmd("mid1", 32'd8, 3'd7, 4'd0, 1'b0, 1'b0);
      rst_n = 1'b0;
      #1;
      chk("mid.rst", 64'(bus.cmd_rdy), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) begin
         @(negedge clk);
         chk("mid.gone", 64'(bus.cmd_rdy), 64'd0);
      end
      send_row("new", 32'd40, 16'd3, 4'd0, 1'b0);
      expect_cmd("new0", 32'd40, 3'd3, 4'd0, 1'b1, 1'b0);
      chk("new.after", 64'(bus.cmd_rdy), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end
endmodule
